// File: rtl/clkgen_prog_div.sv
`default_nettype none
// ============================================================================
// Module  : clkgen_prog_div
// Purpose : runtime-programmable 50%-duty clock/strobe generator (divide by
//           2*(half_q+1)); optional mid-half-period strobe via CLKGEN_QUARTER_EN
// Revision: 1.0  initial release
// ============================================================================
module clkgen_prog_div #(
  parameter int          DIV_W        = 16,
  parameter int unsigned DEFAULT_HALF = 62,
  parameter logic        IDLE_LVL     = 1'b1
) (
  input  logic             clk_25MHz,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] half_div_i,
  input  logic             div_load_i,
  output logic             div_ack_o,
  output logic             clk_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             quarter_o
);

  localparam logic [DIV_W-1:0] C_DEFAULT_HALF = DIV_W'(DEFAULT_HALF);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] pend_val_q, pend_val_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             ack_q, ack_d;
  logic             w_toggle;
  logic             w_apply;

  always_comb begin
    cnt_d      = cnt_q;
    half_d     = half_q;
    pend_val_d = pend_val_q;
    pend_v_d   = pend_v_q;
    clk_d      = clk_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    ack_d      = 1'b0;

    w_toggle = en_i && (cnt_q == half_q);

    if (!en_i) begin
      // forced return to idle is silent: no strobe
      clk_d = IDLE_LVL;
      cnt_d = '0;
    end else if (w_toggle) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      rise_d = ~clk_q;
      fall_d = clk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // divisor swaps only after a complete high+low pair, or while idle
    w_apply = !en_i || (w_toggle && clk_q);

    if (w_apply && div_load_i) begin
      half_d   = half_div_i;
      pend_v_d = 1'b0;
      ack_d    = 1'b1;
    end else if (w_apply && pend_v_q) begin
      half_d   = pend_val_q;
      pend_v_d = 1'b0;
      ack_d    = 1'b1;
    end else if (div_load_i) begin
      pend_val_d = half_div_i;
      pend_v_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      half_q     <= C_DEFAULT_HALF;
      pend_val_q <= '0;
      pend_v_q   <= 1'b0;
      clk_q      <= IDLE_LVL;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      pend_val_q <= pend_val_d;
      pend_v_q   <= pend_v_d;
      clk_q      <= clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      ack_q      <= ack_d;
    end
  end

`ifdef CLKGEN_QUARTER_EN
  logic quarter_q, quarter_d;

  // evaluated on next-state values so the strobe lines up with the counter
  always_comb begin
    quarter_d = en_i && (cnt_d == (half_d >> 1));
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      quarter_q <= 1'b0;
    end else begin
      quarter_q <= quarter_d;
    end
  end

  assign quarter_o = quarter_q;
`else
  assign quarter_o = 1'b0;
`endif

  assign div_ack_o = ack_q;
  assign clk_o     = clk_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;

endmodule
`default_nettype wire

// File: tb/tb_clkgen_prog_div.sv
`default_nettype none
// ============================================================================
// Module  : tb_clkgen_prog_div
// Purpose : self-checking bench for clkgen_prog_div against a behavioural model
// Revision: 1.0  initial release
// ============================================================================
module tb_clkgen_prog_div;

  localparam int   DIV_W = 16;
  localparam int   DEF   = 62;
  localparam logic IDLE  = 1'b1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en_i = 1'b0;
  logic [DIV_W-1:0] half_div_i = '0;
  logic             div_load_i = 1'b0;
  logic             div_ack_o, clk_o, rise_o, fall_o, quarter_o;

  clkgen_prog_div #(.DIV_W(DIV_W), .DEFAULT_HALF(DEF), .IDLE_LVL(IDLE)) dut (
    .clk_25MHz (clk),
    .rst_n     (rst_n),
    .en_i      (en_i),
    .half_div_i(half_div_i),
    .div_load_i(div_load_i),
    .div_ack_o (div_ack_o),
    .clk_o     (clk_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o),
    .quarter_o (quarter_o)
  );

  always #20 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: level, cycles elapsed in the current half-period,
  // active half divisor and a pending request.
  bit m_lvl;
  int m_el;
  int m_half;
  bit m_pend;
  int m_pval;
  bit e_rise, e_fall, e_ack, e_quar;

  task automatic model_reset();
    m_lvl = IDLE; m_el = 0; m_half = DEF; m_pend = 0; m_pval = 0;
    e_rise = 0; e_fall = 0; e_ack = 0; e_quar = 0;
  endtask

  task automatic tick(input bit en, input bit ld, input int div);
    bit apply;
    en_i = en; div_load_i = ld; half_div_i = div[DIV_W-1:0];
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      e_rise = 0; e_fall = 0; e_ack = 0; apply = 0;
      if (!en) begin
        m_lvl = IDLE; m_el = 0; apply = 1;
      end else begin
        m_el++;
        if (m_el == m_half + 1) begin
          m_el = 0;
          if (m_lvl) begin e_fall = 1; apply = 1; end
          else e_rise = 1;
          m_lvl = !m_lvl;
        end
      end
      if (apply && ld) begin m_half = div; m_pend = 0; e_ack = 1; end
      else if (apply && m_pend) begin m_half = m_pval; m_pend = 0; e_ack = 1; end
      else if (ld) begin m_pval = div; m_pend = 1; end
`ifdef CLKGEN_QUARTER_EN
      e_quar = en && (m_el == m_half / 2);
`else
      e_quar = 0;
`endif
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick(0, 0, 0);
    tick(0, 0, 0);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({clk_o, rise_o, fall_o, quarter_o, div_ack_o} !== {IDLE, 4'b0000}) begin
      fails++;
      $display("FAIL reset_state got=%b exp=%b", {clk_o, rise_o, fall_o, quarter_o, div_ack_o}, {IDLE, 4'b0000});
    end
  endtask

  task automatic test_default_period();
    int last_rise = -1;
    int q_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      tick(1, 0, 0);
      tests++;
      if ({clk_o, rise_o, fall_o, quarter_o, div_ack_o} !== {m_lvl, e_rise, e_fall, e_quar, e_ack}) begin
        fails++;
        $display("FAIL default_cycle cyc=%0d got=%b exp=%b", cyc, {clk_o, rise_o, fall_o, quarter_o, div_ack_o}, {m_lvl, e_rise, e_fall, e_quar, e_ack});
      end
      if (cyc == 63) begin
        tests++;
        if (fall_o !== 1'b1) begin fails++; $display("FAIL first_fall cyc=63 got=%b exp=1", fall_o); end
      end
      if (rise_o && last_rise >= 0) begin
        tests++;
        if (cyc - last_rise != 126) begin fails++; $display("FAIL default_period got=%0d exp=126", cyc - last_rise); end
      end
      if (fall_o && last_rise >= 0) begin
        tests++;
        if (cyc - last_rise != 63) begin fails++; $display("FAIL rise_to_fall got=%0d exp=63", cyc - last_rise); end
      end
      if (rise_o) last_rise = cyc;
      if (cyc >= 126 && cyc < 252 && quarter_o === 1'b1) q_cnt++;
    end
    tests++;
`ifdef CLKGEN_QUARTER_EN
    if (q_cnt != 2) begin fails++; $display("FAIL quarter_count got=%0d exp=2", q_cnt); end
`else
    if (q_cnt != 0) begin fails++; $display("FAIL quarter_count got=%0d exp=0", q_cnt); end
`endif
  endtask

  // Advance until the cycle a rise strobe is seen (bounded).
  task automatic wait_rise(input string tag);
    bit seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      tick(1, 0, 0);
      if (rise_o === 1'b1) seen = 1;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL %s no rise_o within bound got=0 exp=1", tag); end
  endtask

  task automatic run_and_measure(input string tag, input int ncyc, input int exp_period,
                                 input int exp_acks);
    int acks = 0;
    int last_rise = -1;
    bit acked = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick(1, 0, 0);
      tests++;
      if ({clk_o, rise_o, fall_o, quarter_o, div_ack_o} !== {m_lvl, e_rise, e_fall, e_quar, e_ack}) begin
        fails++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, {clk_o, rise_o, fall_o, quarter_o, div_ack_o}, {m_lvl, e_rise, e_fall, e_quar, e_ack});
      end
      if (div_ack_o === 1'b1) begin
        acks++; acked = 1;
        tests++;
        if (fall_o !== 1'b1) begin fails++; $display("FAIL %s ack_with_fall got=%b exp=1", tag, fall_o); end
      end
      if (acked && rise_o === 1'b1) begin
        if (last_rise >= 0) begin
          tests++;
          if (cyc - last_rise != exp_period) begin
            fails++; $display("FAIL %s period got=%0d exp=%0d", tag, cyc - last_rise, exp_period);
          end
        end
        last_rise = cyc;
      end
    end
    tests++;
    if (acks != exp_acks) begin fails++; $display("FAIL %s ack_count got=%0d exp=%0d", tag, acks, exp_acks); end
  endtask

  task automatic test_reload();
    wait_rise("reload");
    for (int i = 0; i < 20; i++) tick(1, 0, 0);
    tick(1, 1, 124);
    tests++;
    if (div_ack_o !== 1'b0) begin fails++; $display("FAIL reload_early_ack got=%b exp=0", div_ack_o); end
    run_and_measure("reload", 700, 250, 1);
  endtask

  task automatic test_latest_wins();
    wait_rise("latest");
    tick(1, 1, 10);
    tick(1, 0, 0);
    tick(1, 1, 20);
    run_and_measure("latest", 600, 42, 1);
  endtask

  task automatic test_half_zero();
    bit acked = 0;
    bit prev_rise = 0;
    wait_rise("half0");
    tick(1, 1, 0);
    for (int i = 0; i < 120; i++) begin
      tick(1, 0, 0);
      tests++;
      if ({clk_o, rise_o, fall_o, quarter_o, div_ack_o} !== {m_lvl, e_rise, e_fall, e_quar, e_ack}) begin
        fails++;
        $display("FAIL half0_cycle cyc=%0d got=%b exp=%b", cyc, {clk_o, rise_o, fall_o, quarter_o, div_ack_o}, {m_lvl, e_rise, e_fall, e_quar, e_ack});
      end
      if (acked) begin
        tests++;
        if ((rise_o ^ fall_o) !== 1'b1 || rise_o === prev_rise) begin
          fails++; $display("FAIL half0_alternate cyc=%0d got=r%b/f%b exp=r%b", cyc, rise_o, fall_o, !prev_rise);
        end
      end
      if (div_ack_o === 1'b1) acked = 1;
      prev_rise = rise_o;
    end
    tests++;
    if (!acked) begin fails++; $display("FAIL half0_ack got=0 exp=1"); end
  endtask

  task automatic test_disable();
    bit low_seen = 0;
    int n = 0;
    bit fell = 0;
    do_reset();
    for (int i = 0; i < 200 && !low_seen; i++) begin
      tick(1, 0, 0);
      if (clk_o === 1'b0) low_seen = 1;
    end
    for (int i = 0; i < 5; i++) tick(1, 0, 0);
    tick(0, 0, 0);
    tests++;
    if ({clk_o, rise_o, fall_o} !== {IDLE, 2'b00} || !low_seen) begin
      fails++; $display("FAIL disable_return got=%b exp=%b", {clk_o, rise_o, fall_o}, {IDLE, 2'b00});
    end
    tick(0, 0, 0);
    for (int i = 0; i < 200 && !fell; i++) begin
      tick(1, 0, 0);
      n++;
      if (fall_o === 1'b1) fell = 1;
    end
    tests++;
    if (n != DEF + 1) begin fails++; $display("FAIL reenable_first_fall got=%0d exp=%0d", n, DEF + 1); end
    // load while disabled: ack the following cycle
    tick(0, 0, 0);
    tick(0, 1, 5);
    tests++;
    if (div_ack_o !== 1'b1) begin fails++; $display("FAIL disabled_load_ack got=%b exp=1", div_ack_o); end
    // pending load applies in the first disabled cycle
    tick(1, 0, 0);
    tick(1, 1, 3);
    tick(0, 0, 0);
    tests++;
    if ({div_ack_o, clk_o, rise_o, fall_o} !== {1'b1, IDLE, 2'b00} || e_ack !== 1'b1) begin
      fails++; $display("FAIL pending_on_disable got=%b exp=%b", {div_ack_o, clk_o, rise_o, fall_o}, {1'b1, IDLE, 2'b00});
    end
  endtask

  task automatic test_random();
    bit en, ld;
    int div;
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      ld  = ($urandom_range(0, 19) == 0);
      div = $urandom_range(0, 6);
      tick(en, ld, div);
      tests++;
      if ({clk_o, rise_o, fall_o, quarter_o, div_ack_o} !== {m_lvl, e_rise, e_fall, e_quar, e_ack}) begin
        fails++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {clk_o, rise_o, fall_o, quarter_o, div_ack_o}, {m_lvl, e_rise, e_fall, e_quar, e_ack});
      end
    end
  endtask

  task automatic test_reset_midop();
    int acks = 0;
    do_reset();
    for (int i = 0; i < 10; i++) tick(1, 0, 0);
    tick(1, 1, 9);
    for (int i = 0; i < 80; i++) tick(1, 0, 0);
    #5 rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if ({clk_o, rise_o, fall_o, quarter_o, div_ack_o} !== {IDLE, 4'b0000}) begin
      fails++; $display("FAIL async_reset got=%b exp=%b", {clk_o, rise_o, fall_o, quarter_o, div_ack_o}, {IDLE, 4'b0000});
    end
    for (int i = 0; i < 10; i++) tick(1, 1, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick(1, 0, 0);
      tests++;
      if ({clk_o, rise_o, fall_o, quarter_o, div_ack_o} !== {m_lvl, e_rise, e_fall, e_quar, e_ack}) begin
        fails++;
        $display("FAIL after_reset cyc=%0d got=%b exp=%b", cyc, {clk_o, rise_o, fall_o, quarter_o, div_ack_o}, {m_lvl, e_rise, e_fall, e_quar, e_ack});
      end
      if (div_ack_o === 1'b1) acks++;
    end
    tests++;
    if (acks != 0) begin fails++; $display("FAIL discarded_pending_ack got=%0d exp=0", acks); end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_reload();
    test_latest_wins();
    test_half_zero();
    test_disable();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
